// File: rtl/cv32e41p_apu_arbiter.sv
// Round-robin arbiter sharing one APU/FPU between NB_CORES cores, with a locked
// request while the FPU stalls, a global in-flight credit limit and tag-routed responses.
module cv32e41p_apu_arbiter #(
    parameter int NB_CORES         = 4,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5,
    parameter int ID_W             = $clog2(NB_CORES)
) (
    input  logic                                                clk_i,
    input  logic                                                rst_ni,
    input  logic [NB_CORES-1:0]                                 core_req_i,
    output logic [NB_CORES-1:0]                                 core_gnt_o,
    input  logic [NB_CORES-1:0][APU_NARGS_CPU-1:0][31:0]        core_operands_i,
    input  logic [NB_CORES-1:0][APU_WOP_CPU-1:0]                core_op_i,
    input  logic [NB_CORES-1:0][APU_NDSFLAGS_CPU-1:0]           core_flags_i,
    output logic [NB_CORES-1:0]                                 core_rvalid_o,
    output logic [31:0]                                         core_rdata_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                         core_rflags_o,
    output logic                                                apu_req_o,
    input  logic                                                apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                      apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                              apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                         apu_flags_o,
    output logic [ID_W-1:0]                                     apu_tag_o,
    input  logic                                                apu_rvalid_i,
    input  logic [31:0]                                         apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                         apu_rflags_i,
    input  logic [ID_W-1:0]                                     apu_tag_i
);

    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NB_CORES - 1);

    logic [ID_W-1:0]             r_rr;
    logic                        r_lock;
    logic [ID_W-1:0]             r_lock_id;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_rsp_valid;
    logic [ID_W-1:0]             r_rsp_id;
    logic [31:0]                 r_rsp_data;
    logic [APU_NUSFLAGS_CPU-1:0] r_rsp_flags;

    logic                        w_found;
    logic [ID_W-1:0]             w_scan_id;
    logic [ID_W-1:0]             w_winner;
    logic                        w_has_winner;
    logic                        w_accept;
    logic [ID_W-1:0]             w_rr_next;

    // First requester at or after the priority pointer, wrapping modulo NB_CORES.
    always_comb begin
        w_found   = 1'b0;
        w_scan_id = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            automatic int idx = int'(r_rr) + k;
            if (idx >= NB_CORES) idx = idx - NB_CORES;
            if (!w_found && core_req_i[ID_W'(idx)]) begin
                w_found   = 1'b1;
                w_scan_id = ID_W'(idx);
            end
        end
    end

    assign w_winner     = r_lock ? r_lock_id : w_scan_id;
    assign w_has_winner = r_lock | w_found;
    assign apu_req_o    = w_has_winner && (r_cnt < CNT_MAX);
    assign w_accept     = apu_req_o & apu_gnt_i;
    assign w_rr_next    = (w_winner == LAST_ID) ? '0 : w_winner + ID_W'(1);

    assign apu_operands_o = core_operands_i[w_winner];
    assign apu_op_o       = core_op_i[w_winner];
    assign apu_flags_o    = core_flags_i[w_winner];
    assign apu_tag_o      = w_winner;

    always_comb begin
        core_gnt_o = '0;
        if (w_accept) core_gnt_o[w_winner] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr      <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_accept) begin
            r_rr   <= w_rr_next;
            r_lock <= 1'b0;
        end else if (apu_req_o) begin
            // FPU stalled: pin the selection so the request payload cannot change.
            r_lock    <= 1'b1;
            r_lock_id <= w_winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            case ({w_accept, apu_rvalid_i})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                // Results for operations issued before a reset must not wrap the counter.
                2'b01:   r_cnt <= (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            r_rsp_valid <= apu_rvalid_i;
            if (apu_rvalid_i) begin
                r_rsp_id    <= apu_tag_i;
                r_rsp_data  <= apu_rdata_i;
                r_rsp_flags <= apu_rflags_i;
            end
        end
    end

    for (genvar i = 0; i < NB_CORES; i++) begin : g_rvalid
        assign core_rvalid_o[i] = r_rsp_valid && (r_rsp_id == ID_W'(i));
    end

    assign core_rdata_o  = r_rsp_data;
    assign core_rflags_o = r_rsp_flags;

endmodule

// File: tb/tb_cv32e41p_apu_arbiter.sv
// Bench for cv32e41p_apu_arbiter: directed stimulus with literal expectations plus a
// cycle-level behavioural model (in-flight count, priority pointer, held selection).
module tb_cv32e41p_apu_arbiter;

    localparam int NB    = 4;
    localparam int MAXO  = 2;
    localparam int NARGS = 3;
    localparam int WOP   = 6;
    localparam int NDS   = 15;
    localparam int NUS   = 5;
    localparam int IDW   = 2;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [NB-1:0]                 core_req = '0;
    logic [NB-1:0]                 core_gnt;
    logic [NB-1:0][NARGS-1:0][31:0] core_ops = '0;
    logic [NB-1:0][WOP-1:0]        core_op = '0;
    logic [NB-1:0][NDS-1:0]        core_fl = '0;
    logic [NB-1:0]                 core_rvalid;
    logic [31:0]                   core_rdata;
    logic [NUS-1:0]                core_rflags;
    logic                          apu_req;
    logic                          apu_gnt = 1'b0;
    logic [NARGS-1:0][31:0]        apu_ops;
    logic [WOP-1:0]                apu_op;
    logic [NDS-1:0]                apu_fl;
    logic [IDW-1:0]                apu_tag_o;
    logic                          apu_rvalid = 1'b0;
    logic [31:0]                   apu_rdata = '0;
    logic [NUS-1:0]                apu_rflags = '0;
    logic [IDW-1:0]                apu_tag_i = '0;

    always #5 clk = ~clk;

    cv32e41p_apu_arbiter #(
        .NB_CORES(NB), .MAX_OUTSTANDING(MAXO), .APU_NARGS_CPU(NARGS),
        .APU_WOP_CPU(WOP), .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS), .ID_W(IDW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req), .core_gnt_o(core_gnt),
        .core_operands_i(core_ops), .core_op_i(core_op), .core_flags_i(core_fl),
        .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_rflags_o(core_rflags),
        .apu_req_o(apu_req), .apu_gnt_i(apu_gnt),
        .apu_operands_o(apu_ops), .apu_op_o(apu_op), .apu_flags_o(apu_fl),
        .apu_tag_o(apu_tag_o),
        .apu_rvalid_i(apu_rvalid), .apu_rdata_i(apu_rdata),
        .apu_rflags_i(apu_rflags), .apu_tag_i(apu_tag_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pointer, held selection, number of operations in flight, last-cycle result.
    int          m_rr = 0;
    bit          m_lock = 0;
    int          m_lock_id = 0;
    int          m_inflight = 0;
    bit          m_rv = 0;
    int          m_rtag = 0;
    logic [31:0] m_rdata = '0;
    logic [NUS-1:0] m_rflags = '0;

    always @(negedge clk) begin : compare
        int w;
        int c;
        bit ereq;
        bit acc;
        logic [NB-1:0] egnt;
        logic [NB-1:0] erv;
        if (!rst_n) begin
            m_rr = 0; m_lock = 0; m_lock_id = 0; m_inflight = 0;
            m_rv = 0; m_rtag = 0; m_rdata = '0; m_rflags = '0;
            chk("rst_rvalid", core_rvalid, '0);
            chk("rst_rdata", core_rdata, '0);
            chk("rst_rflags", core_rflags, '0);
            if (core_req == '0) begin
                chk("rst_req", apu_req, 1'b0);
                chk("rst_gnt", core_gnt, '0);
            end
        end else begin
            w = -1;
            if (m_lock) w = m_lock_id;
            else
                for (int k = 0; k < NB; k++) begin
                    c = (m_rr + k) % NB;
                    if (w < 0 && core_req[c]) w = c;
                end
            ereq = (w >= 0) && (m_inflight < MAXO);
            acc  = ereq && apu_gnt;
            egnt = acc ? NB'(1 << w) : '0;
            chk("m_apu_req", apu_req, ereq);
            chk("m_gnt", core_gnt, egnt);
            if (ereq) begin
                chk("m_tag", apu_tag_o, w);
                chk("m_operands", apu_ops, core_ops[w]);
                chk("m_op", apu_op, core_op[w]);
                chk("m_flags", apu_fl, core_fl[w]);
            end
            erv = (m_rv && m_rtag < NB) ? NB'(1 << m_rtag) : '0;
            chk("m_rvalid", core_rvalid, erv);
            chk("m_rdata", core_rdata, m_rdata);
            chk("m_rflags", core_rflags, m_rflags);
            if (acc) begin
                m_rr = (w + 1) % NB;
                m_lock = 0;
            end else if (ereq) begin
                m_lock = 1;
                m_lock_id = w;
            end
            m_inflight = m_inflight + (acc ? 1 : 0) - (apu_rvalid ? 1 : 0);
            if (m_inflight < 0) m_inflight = 0;
            m_rv = apu_rvalid;
            if (apu_rvalid) begin
                m_rtag = int'(apu_tag_i);
                m_rdata = apu_rdata;
                m_rflags = apu_rflags;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : drive
        for (int c = 0; c < NB; c++) begin
            for (int a = 0; a < NARGS; a++) core_ops[c][a] = 32'h1000_0000 * (c + 1) + a;
            core_op[c] = WOP'(c + 8);
            core_fl[c] = NDS'(c * 3 + 1);
        end
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        peek();
        chk("idle_req", apu_req, 1'b0);
        chk("idle_gnt", core_gnt, 4'b0000);
        chk("idle_rvalid", core_rvalid, 4'b0000);
        chk("idle_rdata", core_rdata, 32'h0);

        // Result for tag 2 with nothing in flight.
        cyc();
        apu_rvalid = 1'b1; apu_tag_i = 2'd2; apu_rdata = 32'h3F80_0000; apu_rflags = 5'h03;
        peek();
        cyc();
        apu_rvalid = 1'b0;
        peek();
        chk("rsp_tag2_rvalid", core_rvalid, 4'b0100);
        chk("rsp_tag2_rdata", core_rdata, 32'h3F80_0000);
        chk("rsp_tag2_rflags", core_rflags, 5'h03);

        // Round robin with all cores requesting; one result returns per cycle.
        cyc();
        core_req = 4'b1111; apu_gnt = 1'b1;
        for (int g = 0; g < 6; g++) begin
            peek();
            chk("rr_gnt", core_gnt, 4'b0001 << (g % 4));
            chk("rr_tag", apu_tag_o, g % 4);
            cyc();
            apu_rvalid = 1'b1; apu_tag_i = IDW'(g % 4); apu_rdata = 32'hA000_0000 + g;
            if (g == 5) core_req = 4'b0000;
        end
        peek();
        chk("rr_drain_req", apu_req, 1'b0);
        cyc();
        apu_rvalid = 1'b0;

        // Core 1 stalls on the FPU; core 0 joins while the selection is held.
        core_req = 4'b0010; apu_gnt = 1'b0;
        peek();
        chk("lock_req_c1", apu_req, 1'b1);
        chk("lock_tag_c1", apu_tag_o, 2'd1);
        chk("lock_opnd_c1", apu_ops[0], 32'h2000_0000);
        cyc();
        core_req = 4'b0011;
        peek();
        chk("lock_hold_req", apu_req, 1'b1);
        chk("lock_hold_tag", apu_tag_o, 2'd1);
        chk("lock_hold_gnt", core_gnt, 4'b0000);
        chk("lock_hold_opnd", apu_ops[2], 32'h2000_0002);
        cyc();
        peek();
        chk("lock_hold2_tag", apu_tag_o, 2'd1);
        cyc();
        apu_gnt = 1'b1;
        peek();
        chk("lock_release_gnt", core_gnt, 4'b0010);
        cyc();
        core_req = 4'b0001;
        peek();
        chk("lock_next_gnt", core_gnt, 4'b0001);
        chk("lock_next_tag", apu_tag_o, 2'd0);
        cyc();

        // Credit limit reached: two operations in flight.
        core_req = 4'b0100;
        peek();
        chk("credit_full_req", apu_req, 1'b0);
        chk("credit_full_gnt", core_gnt, 4'b0000);
        cyc();
        peek();
        chk("credit_full_req2", apu_req, 1'b0);
        cyc();
        apu_rvalid = 1'b1; apu_tag_i = 2'd3; apu_rdata = 32'hCAFE_0003; apu_rflags = 5'h11;
        peek();
        chk("credit_no_bypass", apu_req, 1'b0);
        cyc();
        apu_tag_i = 2'd0; apu_rdata = 32'hCAFE_0000; apu_rflags = 5'h04;
        peek();
        chk("credit_freed_gnt", core_gnt, 4'b0100);
        chk("ooo_rvalid3", core_rvalid, 4'b1000);
        chk("ooo_rdata3", core_rdata, 32'hCAFE_0003);
        cyc();
        apu_rvalid = 1'b0; core_req = 4'b1000;
        peek();
        chk("ooo_rvalid0", core_rvalid, 4'b0001);
        chk("ooo_rdata0", core_rdata, 32'hCAFE_0000);
        chk("same_cycle_cnt_gnt", core_gnt, 4'b1000);
        cyc();
        core_req = 4'b0001;
        peek();
        chk("cnt_full_again", apu_req, 1'b0);
        cyc();

        // Free one credit, lock core 0, then reset mid-operation.
        apu_rvalid = 1'b1; apu_tag_i = 2'd2; apu_rdata = 32'h5555_0002;
        peek();
        cyc();
        apu_rvalid = 1'b0; apu_gnt = 1'b0;
        peek();
        chk("pre_rst_lock_req", apu_req, 1'b1);
        cyc();
        rst_n = 1'b0; core_req = 4'b0000;
        peek();
        chk("mid_rst_rvalid", core_rvalid, 4'b0000);
        chk("mid_rst_rdata", core_rdata, 32'h0);
        cyc();
        rst_n = 1'b1;
        apu_rvalid = 1'b1; apu_tag_i = 2'd3; apu_rdata = 32'h1234_5678; apu_rflags = 5'h1F;
        peek();
        cyc();
        apu_rvalid = 1'b0; core_req = 4'b1111; apu_gnt = 1'b1;
        peek();
        chk("stale_rvalid", core_rvalid, 4'b1000);
        chk("stale_rdata", core_rdata, 32'h1234_5678);
        chk("post_rst_gnt0", core_gnt, 4'b0001);
        cyc();
        peek();
        chk("post_rst_gnt1", core_gnt, 4'b0010);
        cyc();
        peek();
        chk("post_rst_gnt_blocked", core_gnt, 4'b0000);
        chk("post_rst_req_blocked", apu_req, 1'b0);
        cyc();
        core_req = 4'b0000; apu_gnt = 1'b0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e41p_apu_arbiter.md
# cv32e41p_apu_arbiter

Shares one APU/FPU instance (fpnew wrapper) between NB_CORES requesting cores. Round-robin arbitration with a stable, locked request toward the FPU. Global outstanding-operation credit limit. Tag-based routing of registered responses back to the issuing core. Sits between the cores' APU master ports and the shared FPU's request/response channels; the FPU carries an ID tag from request to result.

## Interface
- NB_CORES, 4: number of requesting cores (≥2).
- MAX_OUTSTANDING, 4: maximum operations in flight in the FPU (≥1).
- ID_W, $clog2(NB_CORES): tag width.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- core_req_i  in  NB_CORES  per-core request; held high until granted.
- core_gnt_o  out  NB_CORES  per-core grant (combinational); one-hot or zero.
- core_operands_i  in  NB_CORES×APU_NARGS_CPU×32  per-core operands.
- core_op_i  in  NB_CORES×APU_WOP_CPU  per-core operation.
- core_flags_i  in  NB_CORES×APU_NDSFLAGS_CPU  per-core flags.
- core_rvalid_o  out  NB_CORES  per-core result valid; one-cycle pulse.
- core_rdata_o  out  32  result data, shared by all cores.
- core_rflags_o  out  APU_NUSFLAGS_CPU  result flags, shared by all cores.
- apu_req_o  out  1  request to FPU.
- apu_gnt_i  in  1  FPU ready.
- apu_operands_o / apu_op_o / apu_flags_o  out  per-core widths  muxed winner payload.
- apu_tag_o  out  ID_W  winner index.
- apu_rvalid_i  in  1  FPU result valid; no backpressure.
- apu_rdata_i  in  32  FPU result data.
- apu_rflags_i  in  APU_NUSFLAGS_CPU  FPU result flags.
- apu_tag_i  in  ID_W  tag returned with the result.

## Operation
- State:
  - rr_q: priority pointer, 0..NB_CORES-1.
  - lock_q, lock_id_q: held selection.
  - cnt_q: outstanding count, 0..MAX_OUTSTANDING.
  - rsp_valid_q, rsp_id_q, rsp_data_q, rsp_flags_q: response register.
- Selection, when lock_q=0: winner is the first i with core_req_i[i]=1, scanning rr_q, rr_q+1, … with mod-NB_CORES wrap.
- Selection, when lock_q=1: winner is lock_id_q.
- apu_req_o = winner exists AND cnt_q < MAX_OUTSTANDING.
- Payload and apu_tag_o are driven from the winner. Payload is don't-care when apu_req_o=0.
- Accept = apu_req_o AND apu_gnt_i. On accept:
  - core_gnt_o[winner]=1 in the same cycle.
  - rr_q ← (winner+1) mod NB_CORES.
  - lock_q ← 0.
- Lock: when apu_req_o=1 AND apu_gnt_i=0, set lock_q=1 and lock_id_q=winner. The request to the FPU stays stable, with an unchanged payload source, until accepted.
- rr_q is unchanged when there is no accept.
- Credit counter:
  - cnt_q +1 on accept; −1 on apu_rvalid_i; unchanged when both occur in one cycle.
  - At cnt_q=MAX_OUTSTANDING, apu_req_o=0 and any lock is retained.
  - A same-cycle apu_rvalid_i does not bypass the limit.
- Response routing:
  - On apu_rvalid_i, capture data, flags and tag into the response register; rsp_valid_q←1. Otherwise rsp_valid_q←0.
  - core_rvalid_o[i] = rsp_valid_q AND rsp_id_q==i.
  - core_rdata_o and core_rflags_o are driven from the response register at all times.
- A returned tag ≥ NB_CORES produces no core_rvalid_o, but still decrements cnt_q.
- A core may have multiple operations in flight. Results may return in any order; routing uses only the tag.

## Timing
- Reset (async assert, sync deassert in the surrounding design) clears:
  - rr_q=0, lock_q=0, lock_id_q=0, cnt_q=0.
  - rsp_valid_q=0, rsp_id_q=0, rsp_data_q=0, rsp_flags_q=0.
  - Hence core_rvalid_o=0, core_rdata_o=0, core_rflags_o=0.
- With all core_req_i=0: apu_req_o=0 and core_gnt_o=0.
- Request path is combinational: core_req_i to apu_req_o has 0 cycles latency, and core_gnt_o asserts in the accept cycle.
- Response path: core_rvalid_o rises exactly 1 cycle after apu_rvalid_i.
  - Back-to-back apu_rvalid_i gives back-to-back core pulses.
- Throughput: one accept per cycle while apu_gnt_i=1 and credit is available.
- Reset mid-operation: lock, counter and pending response are discarded. FPU results arriving after reset deassertion decrement a saturated-at-0 counter (no underflow) and are routed normally.
- cnt_q never exceeds MAX_OUTSTANDING and never goes below 0.

## Test plan
- Reset, all requests idle:
  - All outputs are 0.
  - apu_rvalid_i=1 with tag=2 and data 0x3F800000 → core_rvalid_o=4'b0100 next cycle, core_rdata_o=0x3F800000, cnt_q stays 0.
- Cores 0–3 request continuously, apu_gnt_i=1, long FPU latency, MAX_OUTSTANDING=8 → grants in the order 0,1,2,3,0,… one per cycle; apu_tag_o matches.
- Core 1 requests and apu_gnt_i=0 for 3 cycles; core 0 raises its request in cycle 2:
  - apu_req_o stays 1 with tag=1 and stable payload.
  - Core 1 is granted when gnt rises; core 0 is granted in the next cycle.
- MAX_OUTSTANDING=2, three accepts attempted with no results → third request held with apu_req_o=0. An apu_rvalid_i then permits it from the following cycle.
- Accept and apu_rvalid_i in the same cycle at cnt_q=1 → cnt_q stays 1.
- Out-of-order return: tags 3 then 0 on consecutive cycles → core_rvalid_o=4'b1000 then 4'b0001 with the matching data.
